// File: rtl/universal_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : universal_reg_pkg
// Description : Shared operation encodings for the universal register.
// Revision    : 1.0 - initial release
// ============================================================================
package universal_reg_pkg;

  // Width of the operation-select field
  localparam int MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  // Operation encodings
  localparam mode_t MODE_HOLD = 3'd0;
  localparam mode_t MODE_LOAD = 3'd1;
  localparam mode_t MODE_SHL  = 3'd2;
  localparam mode_t MODE_SHR  = 3'd3;
  localparam mode_t MODE_ROL  = 3'd4;
  localparam mode_t MODE_ROR  = 3'd5;
  localparam mode_t MODE_INC  = 3'd6;
  localparam mode_t MODE_DEC  = 3'd7;

  // True for the operations that produce a meaningful wrap flag
  function automatic logic mode_is_count(input mode_t m);
    return (m == MODE_INC) || (m == MODE_DEC);
  endfunction

endpackage : universal_reg_pkg
`default_nettype wire

// File: rtl/universal_reg.sv
`default_nettype none
// ============================================================================
// Module      : universal_reg
// Description : Parameterised universal register: hold, parallel load,
//               logical shift with serial fill, rotate, increment and
//               decrement with a registered wrap flag and a zero detect.
// Revision    : 1.0 - initial release
// ============================================================================
module universal_reg
  import universal_reg_pkg::*;
#(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] Q,
  output logic             sout,
  output logic             cout,
  output logic             zero
);

  // Architectural state; every output except zero comes straight from here
  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic             r_cout;

  // Next-state values
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_sout_nxt;
  logic             w_cout_nxt;

  // Bits leaving each end of the register
  logic             w_msb;
  logic             w_lsb;

  assign w_msb = r_q[WIDTH-1];
  assign w_lsb = r_q[0];

  // Next-state selection: clear wins, then enable gating, then the operation.
  // Mode HOLD leaves every register untouched, exactly like en=0, so the
  // wrap flag is only cleared by operations that actually move data.
  always_comb begin
    w_q_nxt    = r_q;
    w_sout_nxt = r_sout;
    w_cout_nxt = r_cout;
    if (clr) begin
      w_q_nxt    = RESET_VAL;
      w_sout_nxt = 1'b0;
      w_cout_nxt = 1'b0;
    end else if (en) begin
      case (mode)
        MODE_HOLD: begin
          w_q_nxt = r_q;
        end
        MODE_LOAD: begin
          w_q_nxt    = D;
          w_cout_nxt = 1'b0;
        end
        MODE_SHL: begin
          w_q_nxt    = {r_q[WIDTH-2:0], sin_r};
          w_sout_nxt = w_msb;
          w_cout_nxt = 1'b0;
        end
        MODE_SHR: begin
          w_q_nxt    = {sin_l, r_q[WIDTH-1:1]};
          w_sout_nxt = w_lsb;
          w_cout_nxt = 1'b0;
        end
        MODE_ROL: begin
          w_q_nxt    = {r_q[WIDTH-2:0], w_msb};
          w_sout_nxt = w_msb;
          w_cout_nxt = 1'b0;
        end
        MODE_ROR: begin
          w_q_nxt    = {w_lsb, r_q[WIDTH-1:1]};
          w_sout_nxt = w_lsb;
          w_cout_nxt = 1'b0;
        end
        MODE_INC: begin
          // Wrap from all-ones to zero raises the flag
          w_q_nxt    = r_q + 1'b1;
          w_cout_nxt = &r_q;
        end
        MODE_DEC: begin
          // Borrow from zero to all-ones raises the flag
          w_q_nxt    = r_q - 1'b1;
          w_cout_nxt = ~|r_q;
        end
        default: begin
          w_q_nxt = r_q;
        end
      endcase
    end
  end

  // State update; reset is asynchronous so the register clears without a clock
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q    <= RESET_VAL;
      r_sout <= 1'b0;
      r_cout <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_sout <= w_sout_nxt;
      r_cout <= w_cout_nxt;
    end
  end

  assign Q    = r_q;
  assign sout = r_sout;
  assign cout = r_cout;

  // Zero detect follows Q within the same cycle
  assign zero = (r_q == '0);

endmodule : universal_reg
`default_nettype wire

// File: doc/universal_reg.md
UNIVERSAL_REG -- requirements
Module: universal_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 4, register width in bits (legal 2..32).
REQ-002 SHALL have parameter RESET_VAL, default 0, value of Q after reset and after synchronous clear.
REQ-003 SHALL have port Clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous clear to RESET_VAL.
REQ-006 SHALL have port en  input  1  operation enable; 0 = hold.
REQ-007 SHALL have port mode  input  3  operation select (see REQ-011).
REQ-008 SHALL have port D  input  WIDTH  parallel load data.
REQ-009 SHALL have ports sin_l, sin_r  input  1 each  serial-in for left-end (MSB) and right-end (LSB) fill.
REQ-010 SHALL have ports Q (output, WIDTH, register contents), sout (output, 1, last bit shifted or rotated out), cout (output, 1, registered wrap flag) and zero (output, 1, combinational Q == 0).

Function
REQ-011 SHALL decode mode: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 INC, 7 DEC.
REQ-012 SHALL apply priority per edge: clr > en=0 (hold) > mode operation.
REQ-013 SHALL on LOAD set Q <= D in one cycle; Q shows D after the edge, with no combinational path from D to Q.
REQ-014 SHALL on SHL set Q <= {Q[WIDTH-2:0], sin_r} and sout <= old Q[WIDTH-1].
REQ-015 SHALL on SHR set Q <= {sin_l, Q[WIDTH-1:1]} and sout <= old Q[0].
REQ-016 SHALL on ROL set Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}, on ROR set Q <= {Q[0], Q[WIDTH-1:1]}, and set sout to the bit that wrapped.
REQ-017 SHALL on INC set Q <= Q+1 modulo 2^WIDTH, and set cout <= 1 only when old Q was all-ones.
REQ-018 SHALL on DEC set Q <= Q-1 modulo 2^WIDTH, and set cout <= 1 only when old Q was 0.
REQ-019 SHALL set cout <= 0 on every enabled non-INC/DEC operation and on clr; while en=0, cout SHALL hold.
REQ-020 SHALL have sout hold its value on HOLD, LOAD, INC, DEC and en=0; clr SHALL set sout <= 0.
REQ-021 SHALL drive zero combinationally from Q, so zero is valid in the same cycle as Q.
REQ-022 SHALL treat mode HOLD with en=1 as identical to en=0.
REQ-023 SHALL ignore D, sin_l and sin_r in every mode that does not use them.

Reset
REQ-024 SHALL, on reset_n low, immediately set Q = RESET_VAL, sout = 0 and cout = 0, independent of Clk.
REQ-025 SHALL hold all outputs at reset values while reset_n is low, regardless of clr, en, mode and D.
REQ-026 SHALL resume operation on the first rising Clk edge after reset_n deasserts; reset asserted mid-operation SHALL discard the operation in progress.

Structure
REQ-027 SHALL take the mode encodings (MODE_HOLD..MODE_DEC) and their width from the shared package universal_reg_pkg.
REQ-028 SHALL be built as one module with a single registered process plus combinational next-state logic; no sub-module is required.
REQ-029 SHALL register all outputs except zero.

Verification (WIDTH=4, RESET_VAL=0)
REQ-030 SHALL cover reset and load: reset_n=0 with mode=LOAD and D=4'hA toggling -> Q=0, cout=0 and sout=0 throughout; release reset, LOAD 4'hA -> Q=4'hA after one edge.
REQ-031 SHALL cover hold: load 4'h5, then en=0 with mode=INC and D sweeping 0..15 for 16 cycles -> Q stays 4'h5 and zero=0.
REQ-032 SHALL cover shifts: load 4'b1001, SHL with sin_r=0 -> Q=4'b0010 and sout=1; then SHR with sin_l=1 -> Q=4'b1001 and sout=0.
REQ-033 SHALL cover rotate: load 4'b1000, ROL four times -> Q sequence 0001, 0010, 0100, 1000; ROR once -> Q=0100 and sout=0.
REQ-034 SHALL cover count wrap: load 4'hE, INC, INC -> Q=4'hF with cout=0, then Q=4'h0 with cout=1 and zero=1; DEC -> Q=4'hF with cout=1; LOAD 4'h3 -> cout=0.
REQ-035 SHALL cover clear priority and async reset: Q=4'h7, clr=1 with en=1 and mode=INC -> Q=0; then pulse reset_n low between Clk edges during INC -> Q=0 immediately, before the next edge.
